esm_issue_queue: RTL and testbench

- Next-generation instruction buffer for the ESM datapath. It is a circular queue with a valid/ready write side and a multi-lane issue side that can take up to ISSUE_W instructions per cycle.
- Adds occupancy reporting, flush, and a mark/rewind replay mechanism so ESM_Core can re-issue a loop body without refetching.
- Sits between the instruction fetch stream and ESM_Core, replacing the free-running buffer index counter.

---
 rtl/esm_pkg.sv | 15 +
 rtl/esm_buf_ram.sv | 29 ++
 rtl/esm_issue_queue.sv | 111 +++++++++++
 tb/tb_esm_issue_queue.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared defaults and pointer arithmetic for the ESM issue queue.
package esm_pkg;

    localparam int ESM_WORD_W = 16;
    localparam int ESM_BS     = 16;
    localparam int PTR_W      = $clog2(ESM_BS);

    // Depth is a power of two, so wrapping is a mask rather than a divide.
    function automatic int unsigned ptr_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
        return (ptr + inc) & (depth - 1);
    endfunction

endpackage

// File: rtl/esm_buf_ram.sv
// Instruction storage: one synchronous write port, LANES combinational read ports.
module esm_buf_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 16,
    parameter int LANES = 2
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [$clog2(DEPTH)-1:0]          waddr,
    input  logic [W-1:0]                      wdata,
    input  logic [LANES*$clog2(DEPTH)-1:0]    raddr,
    output logic [LANES*W-1:0]                rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_rd
        assign rdata[k*W +: W] = mem[raddr[k*AW +: AW]];
    end

endmodule

// File: rtl/esm_issue_queue.sv
// Circular instruction queue with multi-lane issue, flush, and mark/rewind replay.
module esm_issue_queue
    import esm_pkg::*;
#(
    parameter int Instruction_word_size = ESM_WORD_W,
    parameter int bs                    = ESM_BS,
    parameter int ISSUE_W               = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    input  logic [Instruction_word_size-1:0]       in_instr,
    output logic                                   in_ready,
    output logic [ISSUE_W-1:0]                     out_valid,
    output logic [ISSUE_W*Instruction_word_size-1:0] out_instr,
    input  logic [$clog2(ISSUE_W+1)-1:0]           deq_cnt,
    input  logic                                   flush,
    input  logic                                   mark,
    input  logic                                   rewind,
    input  logic                                   release_mark,
    output logic [$clog2(bs):0]                    count,
    output logic                                   mark_valid
);

    localparam int W  = Instruction_word_size;
    localparam int AW = $clog2(bs);
    localparam int CW = AW + 1;

    logic [AW-1:0]         head;
    logic [AW-1:0]         tail;
    logic [AW-1:0]         mark_ptr;
    logic [CW-1:0]         held;
    logic                  push;
    logic [CW-1:0]         push_w;
    logic [CW-1:0]         deq_ext;
    logic [CW-1:0]         eff;
    logic [CW-1:0]         count_pop;
    logic [ISSUE_W*AW-1:0] raddr;
    logic [ISSUE_W*W-1:0]  rdata;

    // Write side: a word transfers on a rising edge where in_valid && in_ready.
    // in_ready depends only on registered held, never on this cycle's dequeue.
    assign in_ready  = (held < CW'(bs));
    assign push      = in_valid && in_ready && !flush;
    assign push_w    = CW'(push);
    assign deq_ext   = CW'(deq_cnt);
    assign eff       = (deq_ext < count) ? deq_ext : count;
    assign count_pop = count + push_w - eff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            mark_ptr   <= '0;
            held       <= '0;
            mark_valid <= 1'b0;
        end else if (flush) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            held       <= '0;
            mark_valid <= 1'b0;
        end else begin
            if (push) begin
                tail <= AW'(ptr_add(32'(tail), 32'd1, bs));
            end
            if (rewind && mark_valid) begin
                head  <= mark_ptr;
                count <= held + push_w;
                held  <= held + push_w;
            end else begin
                head  <= AW'(ptr_add(32'(head), 32'(eff), bs));
                count <= count_pop;
                if (release_mark) begin
                    mark_valid <= 1'b0;
                    held       <= count_pop;
                end else if (mark) begin
                    // Retention starts at the pre-pop head, so popped lanes stay held.
                    mark_ptr   <= head;
                    mark_valid <= 1'b1;
                    held       <= count + push_w;
                end else if (mark_valid) begin
                    held <= held + push_w;
                end else begin
                    held <= count_pop;
                end
            end
        end
    end

    for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
        assign raddr[k*AW +: AW]   = AW'(ptr_add(32'(head), 32'(k), bs));
        assign out_valid[k]        = (CW'(k) < count);
        assign out_instr[k*W +: W] = out_valid[k] ? rdata[k*W +: W] : '0;
    end

    esm_buf_ram #(
        .W     (W),
        .DEPTH (bs),
        .LANES (ISSUE_W)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (tail),
        .wdata (in_instr),
        .raddr (raddr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_esm_issue_queue.sv
// Directed bench for esm_issue_queue with a queue-based reference model checked every cycle.
module tb_esm_issue_queue;

    localparam int W       = 16;
    localparam int BS      = 16;
    localparam int ISSUE_W = 2;
    localparam int CW      = $clog2(BS) + 1;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic [W-1:0]           in_instr;
    logic                   in_ready;
    logic [ISSUE_W-1:0]     out_valid;
    logic [ISSUE_W*W-1:0]   out_instr;
    logic [1:0]             deq_cnt;
    logic                   flush;
    logic                   mark;
    logic                   rewind;
    logic                   release_mark;
    logic [CW-1:0]          count;
    logic                   mark_valid;

    esm_issue_queue #(
        .Instruction_word_size (W),
        .bs                    (BS),
        .ISSUE_W               (ISSUE_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_instr    (out_instr),
        .deq_cnt      (deq_cnt),
        .flush        (flush),
        .mark         (mark),
        .rewind       (rewind),
        .release_mark (release_mark),
        .count        (count),
        .mark_valid   (mark_valid)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // exp_q holds every retained word, oldest first; the first m_off of them
    // have been issued but are still held for replay.
    logic [W-1:0] exp_q[$];
    int           m_off;
    logic         m_mv;
    int           n_vec;
    int           n_err;
    logic         chk_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic drop(input int n);
        for (int i = 0; i < n; i++) void'(exp_q.pop_front());
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_off = 0;
        m_mv  = 1'b0;
    endtask

    task automatic model_step();
        int   cnt;
        int   eff;
        logic pushed;
        cnt    = exp_q.size() - m_off;
        pushed = in_valid && (exp_q.size() < BS);
        if (flush) begin
            model_reset();
            return;
        end
        if (rewind && m_mv) begin
            m_off = 0;
        end else begin
            eff = (int'(deq_cnt) < cnt) ? int'(deq_cnt) : cnt;
            if (release_mark) begin
                drop(m_off + eff);
                m_off = 0;
                m_mv  = 1'b0;
            end else if (mark) begin
                drop(m_off);
                m_off = eff;
                m_mv  = 1'b1;
            end else if (m_mv) begin
                m_off += eff;
            end else begin
                drop(eff);
            end
        end
        if (pushed) exp_q.push_back(in_instr);
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst && chk_en) begin
            int                 cnt;
            logic [ISSUE_W-1:0] ev;
            logic [ISSUE_W*W-1:0] ei;
            cnt = exp_q.size() - m_off;
            ev  = '0;
            ei  = '0;
            for (int k = 0; k < ISSUE_W; k++) begin
                if (k < cnt) begin
                    ev[k]        = 1'b1;
                    ei[k*W +: W] = exp_q[m_off + k];
                end
            end
            chk("count", 64'(count), 64'(cnt));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < BS));
            chk("mark_valid", 64'(mark_valid), 64'(m_mv));
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("out_instr", 64'(out_instr), 64'(ei));
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic v, input logic [W-1:0] d, input int deq,
                       input logic fl, input logic mk, input logic rw, input logic rl);
        in_valid     = v;
        in_instr     = d;
        deq_cnt      = 2'(deq);
        flush        = fl;
        mark         = mk;
        rewind       = rw;
        release_mark = rl;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic push_w(input logic [W-1:0] d, input int deq);
        cyc(1'b1, d, deq, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int deq);
        cyc(1'b0, '0, deq, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [W-1:0] lane(input int k);
        return out_instr[k*W +: W];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        chk_en = 1'b0;
        model_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        deq_cnt = '0;
        flush = 1'b0;
        mark = 1'b0;
        rewind = 1'b0;
        release_mark = 1'b0;

        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);
        chk("rst_mark_valid", 64'(mark_valid), 64'd0);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // basic fill
        push_w(16'hA001, 0);
        push_w(16'hA002, 0);
        push_w(16'hA003, 0);
        chk("basic_count", 64'(count), 64'd3);
        chk("basic_lane0", 64'(lane(0)), 64'hA001);
        chk("basic_lane1", 64'(lane(1)), 64'hA002);
        chk("basic_valid", 64'(out_valid), 64'b11);

        // multi-issue and clamp
        idle(2);
        chk("multi_count", 64'(count), 64'd1);
        chk("multi_lane0", 64'(lane(0)), 64'hA003);
        chk("multi_valid", 64'(out_valid), 64'b01);
        idle(2);
        chk("clamp_count", 64'(count), 64'd0);
        push_w(16'hC000, 0);
        chk("clamp_next_lane0", 64'(lane(0)), 64'hC000);
        idle(1);

        // full and wrap
        for (int i = 0; i < 16; i++) push_w(16'hD000 + 16'(i), 0);
        chk("full_count", 64'(count), 64'd16);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        push_w(16'hD0FF, 0);
        chk("full_drop_count", 64'(count), 64'd16);
        idle(2);
        push_w(16'hE000, 0);
        push_w(16'hE001, 0);
        chk("wrap_lane0", 64'(lane(0)), 64'hD002);
        chk("wrap_lane1", 64'(lane(1)), 64'hD003);
        for (int i = 0; i < 7; i++) idle(2);
        chk("wrap_tail_lane0", 64'(lane(0)), 64'hE000);
        chk("wrap_tail_lane1", 64'(lane(1)), 64'hE001);
        idle(2);
        chk("wrap_empty", 64'(count), 64'd0);

        // mark / rewind loop
        for (int i = 0; i < 4; i++) push_w(16'hB000 + 16'(i), 0);
        cyc(1'b0, '0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        chk("mark_count", 64'(count), 64'd0);
        chk("mark_valid", 64'(mark_valid), 64'd1);
        chk("mark_in_ready", 64'(in_ready), 64'd1);
        cyc(1'b0, '0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rewind_count", 64'(count), 64'd4);
        chk("rewind_lane0", 64'(lane(0)), 64'hB000);
        chk("rewind_lane1", 64'(lane(1)), 64'hB001);
        for (int i = 0; i < 12; i++) push_w(16'hF000 + 16'(i), 2);
        chk("held_full_in_ready", 64'(in_ready), 64'd0);
        chk("held_full_count", 64'(count), 64'd1);
        chk("held_full_lane0", 64'(lane(0)), 64'hF00B);
        push_w(16'hF0FF, 0);
        chk("held_full_drop", 64'(count), 64'd1);
        cyc(1'b0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("release_in_ready", 64'(in_ready), 64'd1);
        chk("release_mark_valid", 64'(mark_valid), 64'd0);

        // simultaneous events
        cyc(1'b0, '0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h7777, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_mark_valid", 64'(mark_valid), 64'd0);
        idle(0);
        chk("flush_no_word", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++) push_w(16'h6000 + 16'(i), 0);
        cyc(1'b0, '0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 16'h6004, 2, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rewind_push_count", 64'(count), 64'd5);
        chk("rewind_push_lane0", 64'(lane(0)), 64'h6000);

        // async reset mid-stream
        cyc(1'b0, '0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) push_w(16'h8000 + 16'(i), 0);
        chk("pre_reset_count", 64'(count), 64'd7);
        in_valid = 1'b1;
        in_instr = 16'h8FFF;
        #2;
        rst = 1'b0;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_in_ready", 64'(in_ready), 64'd1);
        chk("async_mark_valid", 64'(mark_valid), 64'd0);
        model_reset();
        in_valid = 1'b0;
        #4;
        rst = 1'b1;
        push_w(16'h9000, 0);
        idle(0);
        chk("post_reset_count", 64'(count), 64'd1);
        chk("post_reset_lane0", 64'(lane(0)), 64'h9000);
        chk("post_reset_valid", 64'(out_valid), 64'b01);
        idle(1);
        idle(0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
